// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI responder emulating an 8-channel, 12-bit serial ADC
// (ADC128S022 style). SCLK, CS_N and DIN are synchronised into clk_clk and
// their edges drive a frame shifter. Each frame returns the channel addressed
// in the previous frame. The first frame after CS_N falls always returns
// channel 0.
module adc_spi_responder #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic                     adc_sclk,
  input  logic                     adc_cs_n,
  input  logic                     adc_din,
  output logic                     adc_dout,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     sample_strobe,
  output logic [2:0]               sample_ch,
  output logic                     frame_active,
  output logic [7:0]               abort_count
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  localparam int unsigned CNT_W    = $clog2(FRAME_BITS);
  localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]    LAST_BIT    = CNT_W'(FRAME_BITS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q,  din_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q,   cs_prev_d;
  logic [SETTLE_W-1:0]    settle_q,    settle_d;
  logic                   armed_q,     armed_d;

  logic [0:0]             state_q,     state_d;
  logic [FRAME_BITS-1:0]  shifter_q,   shifter_d;
  logic [CNT_W-1:0]       bit_cnt_q,   bit_cnt_d;
  logic [CNT_W-1:0]       rise_cnt_q,  rise_cnt_d;
  logic [2:0]             next_ch_q,   next_ch_d;
  logic [2:0]             sample_ch_q, sample_ch_d;
  logic                   strobe_q,    strobe_d;
  logic [7:0]             abort_q,     abort_d;

  logic                   sclk_s, cs_s, din_s, settled;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [2:0]             load_ch;
  logic [DATA_W-1:0]      sel_word;
  logic [FRAME_BITS-1:0]  load_word;

  // Synchroniser chains, previous-value registers and the post-reset settle gate
  always_comb begin
    sclk_sync_d = SYNC_STAGES'({sclk_sync_q, adc_sclk});
    cs_sync_d   = SYNC_STAGES'({cs_sync_q, adc_cs_n});
    din_sync_d  = SYNC_STAGES'({din_sync_q, adc_din});
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    din_s       = din_sync_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    settled     = (settle_q == SETTLE_DONE);
    settle_d    = settled ? settle_q : settle_q + SETTLE_W'(1);
    // A frame may only start once CS_N has been seen high after reset
    armed_d     = armed_q | (settled & cs_s);
    sclk_rise   = sclk_s & ~sclk_prev_q;
    sclk_fall   = ~sclk_s & sclk_prev_q;
    cs_rise     = cs_s & ~cs_prev_q;
    cs_fall     = ~cs_s & cs_prev_q;
  end

  // Channel word to snapshot: channel 0 on frame start, else the addressed one
  always_comb begin
    load_ch  = (state_q == S_IDLE) ? 3'd0 : next_ch_q;
    sel_word = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (k == 32'(load_ch)) sel_word = ch_data[k*DATA_W +: DATA_W];
    end
    load_word = {{(FRAME_BITS-DATA_W){1'b0}}, sel_word};
  end

  // Frame control: start, shift, reload, CS_N-rise end/abort
  always_comb begin
    state_d     = state_q;
    shifter_d   = shifter_q;
    bit_cnt_d   = bit_cnt_q;
    rise_cnt_d  = rise_cnt_q;
    next_ch_d   = next_ch_q;
    sample_ch_d = sample_ch_q;
    strobe_d    = 1'b0;
    abort_d     = abort_q;
    case (state_q)
      S_IDLE: begin
        // A simultaneous SCLK fall is ignored: load only, no shift
        if (armed_q && cs_fall) begin
          state_d     = S_ACTIVE;
          shifter_d   = load_word;
          bit_cnt_d   = '0;
          rise_cnt_d  = '0;
          next_ch_d   = '0;
          sample_ch_d = '0;
          strobe_d    = 1'b1;
        end
      end
      default: begin
        if (cs_rise) begin
          // Either counter non-zero means the frame was cut short or unbalanced
          if (bit_cnt_q != '0 || rise_cnt_q != '0) begin
            abort_d = (abort_q == 8'hFF) ? abort_q : abort_q + 8'd1;
          end
          state_d = S_IDLE;
        end else begin
          if (sclk_rise) begin
            // Rises 3..5 carry ADD2..ADD0
            if (rise_cnt_q == CNT_W'(2) || rise_cnt_q == CNT_W'(3) ||
                rise_cnt_q == CNT_W'(4)) begin
              next_ch_d = {next_ch_q[1:0], din_s};
            end
            rise_cnt_d = (rise_cnt_q == LAST_BIT) ? '0 : rise_cnt_q + CNT_W'(1);
          end
          if (sclk_fall) begin
            if (bit_cnt_q == LAST_BIT) begin
              shifter_d   = load_word;
              bit_cnt_d   = '0;
              sample_ch_d = next_ch_q;
              strobe_d    = 1'b1;
            end else begin
              shifter_d = {shifter_q[FRAME_BITS-2:0], 1'b0};
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      din_sync_q  <= '1;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      state_q     <= S_IDLE;
      shifter_q   <= '0;
      bit_cnt_q   <= '0;
      rise_cnt_q  <= '0;
      next_ch_q   <= '0;
      sample_ch_q <= '0;
      strobe_q    <= 1'b0;
      abort_q     <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      din_sync_q  <= din_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      shifter_q   <= shifter_d;
      bit_cnt_q   <= bit_cnt_d;
      rise_cnt_q  <= rise_cnt_d;
      next_ch_q   <= next_ch_d;
      sample_ch_q <= sample_ch_d;
      strobe_q    <= strobe_d;
      abort_q     <= abort_d;
    end
  end

  assign adc_dout      = (state_q == S_ACTIVE) & shifter_q[FRAME_BITS-1];
  assign frame_active  = (state_q == S_ACTIVE);
  assign sample_strobe = strobe_q;
  assign sample_ch     = sample_ch_q;
  assign abort_count   = abort_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder. Pins are driven on clk negedges. An SPI-event
// model predicts the outputs, which are compared every cycle with a
// SYNC_STAGES+1 clock latency. Literal checks pin the frame contents.
module tb_adc_spi_responder;
  localparam int NUM_CH      = 8;
  localparam int DATA_W      = 12;
  localparam int FRAME_BITS  = 16;
  localparam int SYNC_STAGES = 2;
  localparam int LAG         = SYNC_STAGES;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, sclk, cs_n, din;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     adc_dout, sample_strobe, frame_active;
  logic [2:0]               sample_ch;
  logic [7:0]               abort_count;

  adc_spi_responder #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_BITS(FRAME_BITS), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .adc_sclk(sclk), .adc_cs_n(cs_n),
    .adc_din(din), .adc_dout(adc_dout), .ch_data(ch_data),
    .sample_strobe(sample_strobe), .sample_ch(sample_ch),
    .frame_active(frame_active), .abort_count(abort_count)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int strobe_seen = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model, advanced once per pin event
  logic        m_active, m_armed, m_strobe_pend;
  logic [15:0] m_word;
  int          m_falls, m_rises, m_abort, m_samp_ch;
  logic        m_din_bits [FRAME_BITS];

  function automatic logic [11:0] ch_val(input int a);
    if (a >= NUM_CH) return 12'h000;
    return ch_data[a*DATA_W +: DATA_W];
  endfunction

  task automatic model_event(input logic oc, input logic nc, input logic os,
                             input logic ns, input logic d);
    logic [2:0] a3;
    if (oc && !nc) begin
      if (!m_active && m_armed) begin
        m_active = 1'b1; m_word = {4'b0, ch_val(0)};
        m_falls = 0; m_rises = 0; m_samp_ch = 0; m_strobe_pend = 1'b1;
      end
    end else if (!oc && nc) begin
      m_armed = 1'b1;
      if (m_active) begin
        if (m_falls != 0 || m_rises != 0) m_abort = (m_abort < 255) ? m_abort + 1 : 255;
        m_active = 1'b0;
      end
    end else if (m_active && os && !ns) begin
      m_falls++;
      if (m_falls == FRAME_BITS) begin
        a3 = {m_din_bits[2], m_din_bits[3], m_din_bits[4]};
        m_samp_ch = int'(a3);
        m_word = {4'b0, ch_val(m_samp_ch)};
        m_strobe_pend = 1'b1;
        m_falls = 0;
      end
    end else if (m_active && !os && ns) begin
      m_din_bits[m_rises] = d;
      m_rises = (m_rises + 1) % FRAME_BITS;
    end
  endtask

  // Expectation history: index LAG-1 is what the DUT must show now
  logic       h_dout [LAG], h_act [LAG], h_strobe [LAG];
  logic [7:0] h_abort [LAG];
  logic [2:0] h_ch [LAG];

  function automatic logic exp_dout();
    return m_active ? m_word[15-m_falls] : 1'b0;
  endfunction

  task automatic flush_hist();
    m_strobe_pend = 1'b0;
    for (int i = 0; i < LAG; i++) begin
      h_dout[i] = exp_dout(); h_act[i] = m_active; h_strobe[i] = 1'b0;
      h_abort[i] = 8'(m_abort); h_ch[i] = 3'(m_samp_ch);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sample_strobe) strobe_seen++;
    if (chk_en) begin
      check("cyc_dout",   32'(adc_dout),      32'(h_dout[LAG-1]));
      check("cyc_active", 32'(frame_active),  32'(h_act[LAG-1]));
      check("cyc_strobe", 32'(sample_strobe), 32'(h_strobe[LAG-1]));
      check("cyc_abort",  32'(abort_count),   32'(h_abort[LAG-1]));
      check("cyc_ch",     32'(sample_ch),     32'(h_ch[LAG-1]));
    end
    for (int i = LAG - 1; i > 0; i--) begin
      h_dout[i] = h_dout[i-1]; h_act[i] = h_act[i-1]; h_strobe[i] = h_strobe[i-1];
      h_abort[i] = h_abort[i-1]; h_ch[i] = h_ch[i-1];
    end
    h_dout[0] = exp_dout(); h_act[0] = m_active; h_strobe[0] = m_strobe_pend;
    h_abort[0] = 8'(m_abort); h_ch[0] = 3'(m_samp_ch);
    m_strobe_pend = 1'b0;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic c, input logic s, input logic d);
    logic oc, os;
    @(negedge clk);
    oc = cs_n; os = sclk;
    cs_n = c; sclk = s; din = d;
    model_event(oc, c, os, s, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; chk_en = 1'b0;
    wait_clk(3);
    check("rst_dout",   32'(adc_dout),      32'h0);
    check("rst_active", 32'(frame_active),  32'h0);
    check("rst_strobe", 32'(sample_strobe), 32'h0);
    check("rst_ch",     32'(sample_ch),     32'h0);
    check("rst_abort",  32'(abort_count),   32'h0);
    m_active = 1'b0; m_abort = 0; m_samp_ch = 0; m_falls = 0; m_rises = 0;
    m_word = '0; m_armed = cs_n;
    rst = 1'b0;
    flush_hist();
    chk_en = 1'b1;
    wait_clk(10);
  endtask

  // SCLK cycles at clk/8; bits[15-k] is DOUT after the k-th fall
  task automatic frame(input logic [15:0] dw, input int ncyc, input int chg_after,
                       input logic [11:0] chg_val, output logic [15:0] bits);
    bits = '0;
    bits[15] = adc_dout;
    for (int k = 1; k <= ncyc; k++) begin
      drive(cs_n, 1'b0, din);
      wait_clk(3);
      if (k <= 15) bits[15-k] = adc_dout;
      if (k == chg_after) ch_data[0 +: DATA_W] = chg_val;
      drive(cs_n, 1'b1, dw[16-k]);
      wait_clk(3);
    end
  endtask

  initial begin
    logic [15:0] bits;
    int s0;
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b1; din = 1'b0; ch_data = '0;
    m_active = 1'b0; m_armed = 1'b0; m_strobe_pend = 1'b0; m_word = '0;
    m_falls = 0; m_rises = 0; m_abort = 0; m_samp_ch = 0;
    for (int i = 0; i < FRAME_BITS; i++) m_din_bits[i] = 1'b0;
    flush_hist();
    ch_data[0*DATA_W +: DATA_W] = 12'hABC;
    ch_data[3*DATA_W +: DATA_W] = 12'h5A5;
    ch_data[7*DATA_W +: DATA_W] = 12'h3C7;
    do_reset();

    // Frame 1: ADD=3, returns channel 0
    drive(1'b0, 1'b1, 1'b0); wait_clk(3);
    check("start_strobe_cnt", 32'(strobe_seen), 32'd1);
    check("start_ch", 32'(sample_ch), 32'd0);
    check("start_active", 32'(frame_active), 32'd1);
    frame(16'b0001_1000_0000_0000, 16, 0, 12'h000, bits);
    check("frame1_bits", 32'(bits), 32'h0ABC);
    check("frame1_strobe_cnt", 32'(strobe_seen), 32'd2);
    check("frame1_ch", 32'(sample_ch), 32'd3);

    // Frame 2 back-to-back: ADD=7, returns channel 3
    frame(16'b0011_1000_0000_0000, 16, 0, 12'h000, bits);
    check("frame2_bits", 32'(bits), 32'h05A5);
    check("frame2_ch", 32'(sample_ch), 32'd7);
    check("frame2_abort", 32'(abort_count), 32'd0);

    // Abort after 8 SCLK cycles
    frame(16'h0000, 8, 0, 12'h000, bits);
    drive(1'b1, 1'b1, 1'b0); wait_clk(3);
    check("abort1_cnt", 32'(abort_count), 32'd1);
    check("abort1_dout", 32'(adc_dout), 32'd0);
    check("abort1_active", 32'(frame_active), 32'd0);
    wait_clk(4);
    drive(1'b0, 1'b1, 1'b0); wait_clk(3);
    frame(16'h0000, 16, 0, 12'h000, bits);
    check("restart_bits", 32'(bits), 32'h0ABC);
    drive(1'b1, 1'b1, 1'b0); wait_clk(3);
    check("normal_end_abort", 32'(abort_count), 32'd1);

    // SCLK toggling while idle is ignored
    s0 = strobe_seen;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0); wait_clk(3);
      drive(1'b1, 1'b1, 1'b0); wait_clk(3);
    end
    check("idle_strobe_cnt", 32'(strobe_seen), 32'(s0));
    check("idle_abort", 32'(abort_count), 32'd1);
    check("idle_dout", 32'(adc_dout), 32'd0);

    // CS fall with SCLK fall: load only; the following rise is unmatched
    drive(1'b0, 1'b0, 1'b0); wait_clk(3);
    check("csfall_sclk_active", 32'(frame_active), 32'd1);
    check("csfall_sclk_strobe", 32'(strobe_seen), 32'(s0 + 1));
    drive(1'b0, 1'b1, 1'b0); wait_clk(3);
    drive(1'b1, 1'b1, 1'b0); wait_clk(3);
    check("mismatch_abort", 32'(abort_count), 32'd2);

    // CS rise with SCLK fall after a complete frame: CS wins, no abort
    wait_clk(4);
    drive(1'b0, 1'b1, 1'b0); wait_clk(3);
    frame(16'h0000, 16, 0, 12'h000, bits);
    drive(1'b1, 1'b0, 1'b0); wait_clk(3);
    check("csrise_sclk_abort", 32'(abort_count), 32'd2);
    check("csrise_sclk_active", 32'(frame_active), 32'd0);
    drive(1'b1, 1'b1, 1'b0); wait_clk(3);

    // ch_data changes mid-frame do not disturb the shifted word
    ch_data[0 +: DATA_W] = 12'hFFF;
    drive(1'b0, 1'b1, 1'b0); wait_clk(3);
    frame(16'h0000, 16, 6, 12'h000, bits);
    check("snapshot_bits", 32'(bits), 32'h0FFF);
    drive(1'b1, 1'b1, 1'b0); wait_clk(3);

    // Reset at bit 10 with CS held low
    ch_data[0 +: DATA_W] = 12'h123;
    drive(1'b0, 1'b1, 1'b0); wait_clk(3);
    frame(16'h0000, 10, 0, 12'h000, bits);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0); wait_clk(3);
      drive(1'b0, 1'b1, 1'b0); wait_clk(3);
    end
    check("post_rst_idle", 32'(frame_active), 32'd0);
    drive(1'b1, 1'b1, 1'b0); wait_clk(4);
    drive(1'b0, 1'b1, 1'b0); wait_clk(3);
    check("post_rst_start", 32'(frame_active), 32'd1);
    drive(1'b1, 1'b1, 1'b0); wait_clk(3);
    check("post_rst_abort", 32'(abort_count), 32'd0);

    // Saturation of the abort counter
    for (int i = 0; i < 257; i++) begin
      wait_clk(1);
      drive(1'b0, 1'b1, 1'b0); wait_clk(3);
      drive(1'b0, 1'b0, 1'b0); wait_clk(3);
      drive(1'b0, 1'b1, 1'b0); wait_clk(3);
      drive(1'b1, 1'b1, 1'b0); wait_clk(3);
      if (i == 254) check("abort_255", 32'(abort_count), 32'd255);
    end
    check("abort_sat", 32'(abort_count), 32'd255);

    wait_clk(5);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- SPI slave (responder) that emulates an 8-channel, 12-bit serial ADC of the ADC128S022 type on the adc_sclk/adc_cs_n/adc_din/adc_dout interface.
- Lets the Nios ADC master be exercised in hardware loopback and on the bench without the physical converter.
- Channel values come from a parallel input bus, typically switches, DAC loopback or a pattern generator.
- Sits in the top level, wired to the master pins in place of the external ADC.

Parameters:
- NUM_CH, 8, number of emulated channels; the address field is 3 bits.
- DATA_W, 12, sample width.
- FRAME_BITS, 16, SCLK cycles per frame.
- SYNC_STAGES, 2, synchronizer depth for adc_sclk, adc_cs_n and adc_din.

Ports:
- clk_clk  in  1  system clock; all logic on the rising edge.
- reset_reset  in  1  synchronous, active-high reset.
- adc_sclk  in  1  SPI clock from master; idles high; asynchronous to clk_clk.
- adc_cs_n  in  1  active-low frame select from master.
- adc_din  in  1  master command bits; sampled on SCLK rising edges.
- adc_dout  out  1  serial sample data; changes on SCLK falling edges.
- ch_data  in  NUM_CH*DATA_W  flattened channel values; channel k is bits [k*DATA_W +: DATA_W].
- sample_strobe  out  1  one-clk pulse when a channel value is snapshotted into the shifter.
- sample_ch  out  3  channel number of the most recent snapshot.
- frame_active  out  1  high while a frame is in progress.
- abort_count  out  8  saturating count of frames cut short by CS rising.

Behaviour:
- Reset: all outputs 0; state IDLE; cur_ch=0; next_ch=0.
  - Synchronizer and previous-value registers reset to 1 so the first cycles after reset see no false edges.
  - If cs_n is already low at reset release, the block waits for cs_n high, then a new fall.
- Synchronizing and edge detection:
  - Inputs pass SYNC_STAGES flops, then a previous-value register; edges are detected in clk_clk.
  - Response latency is SYNC_STAGES+1 clk cycles from a pin edge to adc_dout/strobe.
  - Supported SCLK frequency: at most clk_clk/8.
- States:
  - IDLE → ACTIVE on cs_n fall. At the transition:
    - shifter loads {4'b0, ch_data[0]}; cur_ch=0; bit_cnt=0;
    - sample_strobe pulses with sample_ch=0; frame_active=1;
    - adc_dout = shifter MSB.
  - ACTIVE, SCLK rise: shift adc_din into din_sr. Rises 3, 4 and 5 of the frame (counting from 1) capture ADD2..ADD0 MSB first into next_ch.
  - ACTIVE, SCLK fall: bit_cnt++.
    - If bit_cnt < FRAME_BITS-1: shifter shifts left and adc_dout shows the next bit.
    - If bit_cnt == FRAME_BITS-1 (16th fall, frame end): shifter reloads {4'b0, ch_data[next_ch]}; cur_ch=next_ch; bit_cnt=0; sample_strobe pulses with sample_ch=next_ch. The block stays ACTIVE for back-to-back frames.
  - ACTIVE, cs_n rise:
    - If bit_cnt != 0, or a rise/fall mismatch (rise seen without the matching fall): abort. abort_count increments, saturating at 255.
    - If bit_cnt == 0 after a completed frame: normal end, no abort.
    - Either way: IDLE, adc_dout=0, frame_active=0, no strobe. The next frame restarts at channel 0.
- Frame data:
  - Each frame carries DOUT = 4 zeros then DATA_W bits MSB first.
  - The data is the channel addressed in the previous frame; the first frame after CS fall always returns channel 0.
  - The ch_data snapshot is taken only at the reload instant. ch_data changes mid-frame do not affect the bits being shifted.
- Simultaneous events:
  - cs_n rise in the same clk as an SCLK edge: cs_n wins and the edge is ignored.
  - SCLK edges while IDLE are ignored.
  - cs_n fall in the same clk as an SCLK fall: load only, no shift.
- Channel addresses 0..7 are all valid. With NUM_CH<8, addresses ≥ NUM_CH return zero data.
- Reset mid-frame: immediate return to reset values. abort_count is cleared, not incremented.

Test Plan:
- Reset, cs_n low, then 16 SCLK cycles (clk/8) with DIN=16'b0001_1000_0000_0000 (ADD=3), ch_data[0]=12'hABC → adc_dout sequence 0000_1010_1011_1100; strobe at CS fall with sample_ch=0; strobe at the 16th fall with sample_ch=3.
- Continue a second frame with ch_data[3]=12'h5A5, DIN ADD=7 → DOUT 0000_0101_1010_0101; strobe with sample_ch=7; abort_count stays 0.
- CS rise after 8 SCLK cycles → abort_count=1, adc_dout=0, frame_active=0; next frame returns ch_data[0].
- Toggle SCLK 20 times with cs_n high → no strobe, adc_dout=0, abort_count unchanged.
- Change ch_data[0] from 12'hFFF to 12'h000 after the 6th SCLK fall → the current frame still shifts 12'hFFF.
- Assert reset_reset at bit 10 with cs_n held low → outputs 0; no frame starts until cs_n goes high then low; 256 aborts → abort_count saturates at 255.
